fifo_sync_param: RTL and testbench



---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_sync_param_if.sv | 33 +++
 rtl/fifo_mem.sv | 36 +++
 rtl/fifo_sync_param.sv | 90 +++++++++
 tb/tb_fifo_sync_param.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and types for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH = 32;
    localparam int unsigned FIFO_DEPTH = 16;

    // Occupancy counter must hold the value DEPTH itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_sync_param_if.sv
// FIFO handshake/status bundle; master = producer/consumer side, slave = FIFO.
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned DEPTH = FIFO_DEPTH
) ();

    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_op;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_op, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_op, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage, one write port and one read port.
// FIFO_FWFT_EN selects a combinational read; otherwise the read is registered.
module fifo_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

`ifdef FIFO_FWFT_EN
    logic unused_rd;
    assign unused_rd = ^{rst, rd_en};
    assign rd_data   = mem[rd_addr];
`else
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
`endif

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with fill count, almost flags and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through read behaviour.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = FIFO_WIDTH,
    parameter int unsigned DEPTH    = FIFO_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input logic               clk,
    input logic               rst,
    fifo_sync_param_if.slave  bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);
    localparam fifo_status_t RST_STATUS = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                                            almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};

    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic [AW-1:0] rd_ptr, rd_ptr_nxt;
    logic [CW-1:0] count_q, count_nxt;
    fifo_status_t  status_q, status_nxt;
    logic          wr_acc, rd_acc;

    // Acceptance, next pointers/count, and flags derived from the next count.
    always_comb begin
        wr_acc     = bus.wr_en & (~status_q.full | bus.rd_en);
        rd_acc     = bus.rd_en & ~status_q.empty;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count_q;
        status_nxt = status_q;

        if (wr_acc) wr_ptr_nxt = wr_ptr + AW'(1);
        if (rd_acc) rd_ptr_nxt = rd_ptr + AW'(1);

        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase

        status_nxt.full         = (count_nxt == CW'(DEPTH));
        status_nxt.empty        = (count_nxt == '0);
        status_nxt.almost_full  = (count_nxt >= CW'(AF_LEVEL));
        status_nxt.almost_empty = (count_nxt <= CW'(AE_LEVEL));
        status_nxt.overflow     = bus.wr_en & status_q.full & ~bus.rd_en;
        status_nxt.underflow    = bus.rd_en & status_q.empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            status_q <= RST_STATUS;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count_q  <= count_nxt;
            status_q <= status_nxt;
        end
    end

    // Reset wins over any request in the same cycle.
    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc & ~rst),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_en   (rd_acc & ~rst),
        .rd_addr (rd_ptr),
        .rd_data (bus.data_op)
    );

    assign bus.count        = count_q;
    assign bus.full         = status_q.full;
    assign bus.empty        = status_q.empty;
    assign bus.almost_full  = status_q.almost_full;
    assign bus.almost_empty = status_q.almost_empty;
    assign bus.overflow     = status_q.overflow;
    assign bus.underflow    = status_q.underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed vector table plus a randomised scoreboard pass for fifo_sync_param
// (WIDTH=32, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2); honours FIFO_FWFT_EN.
module tb_fifo_sync_param;
    import fifo_pkg::*;

`ifdef FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        wr;
        logic        rd;
        logic [31:0] din;
        int          cnt;
        logic        ovf;
        logic        udf;
        logic        chk;
        logic [31:0] d;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    fifo_sync_param_if #(.WIDTH(32), .DEPTH(16)) bus ();

    fifo_sync_param #(
        .WIDTH    (32),
        .DEPTH    (16),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic [31:0] din,
                                input int cnt, input logic ovf, input logic udf, input logic [31:0] d);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rd; v.din = din; v.cnt = cnt;
        v.ovf = ovf; v.udf = udf; v.chk = 1'b1; v.d = d;
        return v;
    endfunction

    function automatic fifo_status_t exp_status(input int n, input logic ovf, input logic udf);
        fifo_status_t s;
        s.full         = (n == 16);
        s.empty        = (n == 0);
        s.almost_full  = (n >= 14);
        s.almost_empty = (n <= 2);
        s.overflow     = ovf;
        s.underflow    = udf;
        return s;
    endfunction

    // Data order seen while draining after the full-FIFO simultaneous write of 0xAA.
    function automatic logic [31:0] drain_val(input int k);
        return (k < 15) ? 32'(k + 2) : 32'hAA;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int n, input logic ovf, input logic udf,
                                 input logic chk_d, input logic [31:0] d);
        fifo_status_t act;
        act = '{full: bus.full, empty: bus.empty, almost_full: bus.almost_full,
                almost_empty: bus.almost_empty, overflow: bus.overflow, underflow: bus.underflow};
        check({tag, " count"}, 32'(bus.count), 32'(n));
        check({tag, " status"}, 32'(act), 32'(exp_status(n, ovf, udf)));
        if (chk_d && !(FWFT && n == 0)) check({tag, " data_op"}, bus.data_op, d);
    endtask

    task automatic drive_cycle(input logic r, input logic w, input logic rd, input logic [31:0] din);
        rst         = r;
        bus.wr_en   = w;
        bus.rd_en   = rd;
        bus.data_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] m_d;
        logic        w, r, ovf_e, udf_e;
        logic [31:0] din;

        rst = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;

        // Reset state
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        // Fill with 0x1..0x10, then an overflow attempt
        for (int i = 1; i <= 16; i++)
            vecs.push_back(mk(0, 1, 0, 32'(i), i, 0, 0, FWFT ? 32'h1 : 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'hDEAD, 16, 1, 0, FWFT ? 32'h1 : 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 16, 0, 0, FWFT ? 32'h1 : 32'h0));
        // Drain in order, then an underflow attempt that must hold data_op
        for (int i = 1; i <= 16; i++)
            vecs.push_back(mk(0, 0, 1, 0, 16 - i, 0, 0, FWFT ? 32'(i + 1) : 32'(i)));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 32'h10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h10));
        // Refill, then simultaneous write/read while full
        for (int i = 1; i <= 16; i++)
            vecs.push_back(mk(0, 1, 0, 32'(i), i, 0, 0, FWFT ? 32'h1 : 32'h10));
        vecs.push_back(mk(0, 1, 1, 32'hAA, 16, 0, 0, FWFT ? 32'h2 : 32'h1));
        for (int k = 1; k <= 16; k++)
            vecs.push_back(mk(0, 0, 1, 0, 16 - k, 0, 0, FWFT ? drain_val(k) : drain_val(k - 1)));
        // Simultaneous write/read while empty
        vecs.push_back(mk(0, 1, 1, 32'h55, 1, 0, 1, FWFT ? 32'h55 : 32'hAA));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h55));
        // Reset mid-operation with wr_en high
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(0, 1, 0, 32'h100 + 32'(i), i, 0, 0, FWFT ? 32'h101 : 32'h55));
        vecs.push_back(mk(1, 1, 0, 32'h99, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h77, 1, 0, 0, FWFT ? 32'h77 : 32'h0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h77));

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            check_outputs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].udf,
                          vecs[i].chk, vecs[i].d);
        end

        // Random interleaving against a queue model: write-heavy, then read-heavy
        m_d = 32'h77;
        for (int c = 0; c < 160; c++) begin
            w   = ($urandom_range(0, 9) < ((c < 80) ? 7 : 3));
            r   = ($urandom_range(0, 9) < ((c < 80) ? 3 : 7));
            din = $urandom;
            ovf_e = w && (q.size() == 16) && !r;
            udf_e = r && (q.size() == 0);
            drive_cycle(1'b0, w, r, din);
            if (r && q.size() > 0) m_d = q.pop_front();
            if (w && (q.size() < 16 || r)) q.push_back(din);
            check_outputs($sformatf("rnd%0d", c), q.size(), ovf_e, udf_e, 1'b1,
                          FWFT ? ((q.size() > 0) ? q[0] : 32'h0) : m_d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
